fifo_stream_reader: RTL
=======================

// Module: fifo_stream_reader
// PURPOSE
//  Read-side companion to the team's show-ahead FIFO (push/pop, combinational read_data, empty/full).
//  Drains the FIFO and presents words downstream on a valid/ready stream through a registered 2-entry buffer.
//  No combinational path from out_ready to fifo_pop. Sits between each sqrt-pipe result FIFO and its consumer.
// PARAMETERS
//  width   32   data word width; must match the attached FIFO's width
//  cnt_w   16   width of statistics counters (only used with FIFO_READER_STATS_EN)
// PORTS
//  clk          in   1      clock; all logic on posedge
//  rst          in   1      synchronous, active-high reset
//  fifo_empty   in   1      FIFO empty flag
//  fifo_rdata   in   width  FIFO head word, valid whenever !fifo_empty
//  fifo_pop     out  1      pop strobe to FIFO; head word is captured in the same cycle
//  flush        in   1      discard buffered words (FIFO contents untouched)
//  out_valid    out  1      out_data holds a word
//  out_ready    in   1      consumer accepts; transfer = out_valid & out_ready
//  out_data     out  width  oldest buffered word
//  xfer_cnt     out  cnt_w  transfers completed (FIFO_READER_STATS_EN only)
//  stall_cnt    out  cnt_w  cycles with out_valid & !out_ready (FIFO_READER_STATS_EN only)
// BEHAVIOUR
//  - Buffer state: occupancy enum EMPTY(0), ONE(1), TWO(2); slot0 = head (drives out_data), slot1 = tail.
//  - fifo_pop = !fifo_empty & (occ != TWO) & !flush & !rst. It depends only on registered state and
//    FIFO flags; out_ready is never used.
//  - On pop, fifo_rdata is written to the first free slot after the cycle's transfer is accounted for.
//  - Transitions (pop P, transfer T):
//    EMPTY: P -> ONE.
//    ONE:   P&T -> ONE (slot0 <= rdata); P&!T -> TWO; !P&T -> EMPTY.
//    TWO:   T -> ONE (slot0 <= slot1); no pop possible.
//  - out_valid = (occ != EMPTY); out_data = slot0. Both are registered outputs.
//  - Latency: a word at the FIFO head in cycle N, with the buffer EMPTY, appears on out_valid/out_data in cycle N+1.
//  - Throughput: with out_ready held high, one word per cycle is sustained indefinitely at occupancy ONE.
//  - Order: words leave in exactly FIFO order, with no duplication or loss.
//  - Backpressure: out_ready low lets the buffer fill to TWO, then fifo_pop stays low.
//    While out_valid is high and the handshake has not completed, out_data stays stable.
//  - flush (1 cycle): next occ = EMPTY and fifo_pop = 0 in that cycle. A transfer completing in the
//    flush cycle still counts. Flush has priority over pop.
//  - Reset: occ = EMPTY, out_valid = 0, fifo_pop = 0 (combinationally during rst), out_data = '0,
//    counters = 0. Reset mid-stream drops buffered words; the FIFO keeps its contents.
//  - fifo_empty rising in the same cycle as a transfer: normal drain, no pop.
// CONFIGURATION
//  - FIFO_READER_STATS_EN defined: xfer_cnt increments on each transfer. stall_cnt increments on each
//    out_valid & !out_ready cycle. Both counters saturate at all-ones and clear on rst or flush.
//  - Macro undefined: xfer_cnt and stall_cnt are tied to '0 and no counter flops are instantiated.
// STRUCTURE
//  - fifo_reader_pkg: typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t; localparam OCC_MAX = 2.
//  - One sub-module, fifo_reader_buf2: 2-slot data storage plus slot0/slot1 shift.
//    The top level owns the occupancy FSM, pop generation and counters.
// TESTING (bench models the show-ahead FIFO, depth 8, width 32)
//  1. Reset, FIFO empty -> out_valid=0, fifo_pop=0, out_data=0 for 5 cycles.
//  2. Preload 8'h01..8'h08, out_ready=1 -> pops on 8 consecutive cycles; out_data 1..8 on consecutive
//     cycles starting 1 cycle after the first pop.
//  3. Preload 1..4, out_ready=0 -> exactly 2 pops, occ=TWO, out_data=1 held. Raise out_ready ->
//     sequence 1,2,3,4 with no gap after the first accept.
//  4. Random out_ready (50%) over 1000 words -> scoreboard order exact; fifo_pop never asserted while occ=TWO.
//  5. occ=TWO with 5 words left in FIFO, pulse flush -> out_valid=0 next cycle, no pop in the flush
//     cycle, next word out is FIFO head 3.
//  6. FIFO_READER_STATS_EN: 10 transfers plus 4 stall cycles -> xfer_cnt=10, stall_cnt=4.
//     With cnt_w=4, 20 transfers -> xfer_cnt=15 (saturated).

Source files
------------

// File: rtl/fifo_reader_pkg.sv
// Shared types for the FIFO stream reader: buffer occupancy encoding.
package fifo_reader_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  localparam int unsigned OCC_MAX = 2;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus downstream valid/ready stream seen by the reader.
interface fifo_stream_reader_if #(
  parameter int unsigned width = 32
);
  logic             fifo_empty;
  logic [width-1:0] fifo_rdata;
  logic             fifo_pop;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [width-1:0] out_data;

  // master: the FIFO/consumer side that drives the reader
  modport master (
    output fifo_empty, fifo_rdata, flush, out_ready,
    input  fifo_pop, out_valid, out_data
  );

  modport slave (
    input  fifo_empty, fifo_rdata, flush, out_ready,
    output fifo_pop, out_valid, out_data
  );
endinterface

// File: rtl/fifo_reader_buf2.sv
// Two-slot word storage for the stream reader; slot0 is the head presented downstream.
module fifo_reader_buf2 #(
  parameter int unsigned width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr0,
  input  logic             i_wr1,
  input  logic             i_shift,
  input  logic [width-1:0] i_wdata,
  output logic [width-1:0] o_slot0
);
  logic [width-1:0] r_slot0;
  logic [width-1:0] r_slot1;

  // A write to slot0 overrides the shift; the controller never asserts both.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot0 <= '0;
      r_slot1 <= '0;
    end else begin
      if (i_wr0) begin
        r_slot0 <= i_wdata;
      end else if (i_shift) begin
        r_slot0 <= r_slot1;
      end
      if (i_wr1) begin
        r_slot1 <= i_wdata;
      end
    end
  end

  assign o_slot0 = r_slot0;
endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a show-ahead FIFO into a registered 2-entry valid/ready buffer.
// Optional statistics counters are enabled by defining FIFO_READER_STATS_EN.
module fifo_stream_reader
  import fifo_reader_pkg::*;
#(
  parameter int unsigned width = 32,
  parameter int unsigned cnt_w = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_stream_reader_if.slave  bus,
  output logic [cnt_w-1:0]     xfer_cnt,
  output logic [cnt_w-1:0]     stall_cnt
);
  occ_t             r_occ;
  occ_t             w_occ_next;
  logic             w_pop;
  logic             w_xfer;
  logic             w_wr0;
  logic             w_wr1;
  logic             w_shift;
  logic [width-1:0] w_slot0;

  // Pop uses only registered occupancy and FIFO/control flags, never out_ready.
  assign w_pop         = ~bus.fifo_empty & (r_occ != TWO) & ~bus.flush & ~rst;
  assign w_xfer        = bus.out_valid & bus.out_ready;
  assign bus.fifo_pop  = w_pop;
  assign bus.out_valid = (r_occ != EMPTY);
  assign bus.out_data  = w_slot0;

  always_comb begin
    w_occ_next = r_occ;
    w_wr0      = 1'b0;
    w_wr1      = 1'b0;
    w_shift    = 1'b0;
    unique case (r_occ)
      EMPTY: begin
        if (w_pop) begin
          w_occ_next = ONE;
          w_wr0      = 1'b1;
        end
      end
      ONE: begin
        if (w_pop && w_xfer) begin
          w_wr0 = 1'b1;
        end else if (w_pop) begin
          w_occ_next = TWO;
          w_wr1      = 1'b1;
        end else if (w_xfer) begin
          w_occ_next = EMPTY;
        end
      end
      TWO: begin
        if (w_xfer) begin
          w_occ_next = ONE;
          w_shift    = 1'b1;
        end
      end
      default: w_occ_next = EMPTY;
    endcase
    if (bus.flush) begin
      w_occ_next = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ <= EMPTY;
    end else begin
      r_occ <= w_occ_next;
    end
  end

  fifo_reader_buf2 #(
    .width (width)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_wr0   (w_wr0),
    .i_wr1   (w_wr1),
    .i_shift (w_shift),
    .i_wdata (bus.fifo_rdata),
    .o_slot0 (w_slot0)
  );

`ifdef FIFO_READER_STATS_EN
  logic [cnt_w-1:0] r_xfer_cnt;
  logic [cnt_w-1:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_xfer_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_xfer && (r_xfer_cnt != '1)) begin
        r_xfer_cnt <= r_xfer_cnt + cnt_w'(1);
      end
      if (bus.out_valid && !bus.out_ready && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + cnt_w'(1);
      end
    end
  end

  assign xfer_cnt  = r_xfer_cnt;
  assign stall_cnt = r_stall_cnt;
`else
  assign xfer_cnt  = '0;
  assign stall_cnt = '0;
`endif
endmodule
